craps_fsm: RTL and testbench

Game controller for the craps design. It consumes the single-cycle roll pulse produced by the roll-button falling-edge detector. It keeps two free-running dice counters, captures them on each roll and applies the craps rules (come-out roll, point phase, win/lose). Its outputs drive the seven-segment and LED display logic.

---
 rtl/craps_pkg.sv | 18 +
 rtl/dice_counter.sv | 20 ++
 rtl/craps_fsm.sv | 82 ++++++++
 tb/tb_craps_fsm.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/craps_pkg.sv
// craps_pkg: shared state encoding and dice/sum constants for the craps game controller.
package craps_pkg;
    typedef enum logic [2:0] {
        COMEOUT = 3'd0,
        EVAL_C  = 3'd1,
        POINT   = 3'd2,
        EVAL_P  = 3'd3,
        WIN     = 3'd4,
        LOSE    = 3'd5
    } craps_state_t;
    localparam logic [3:0] SUM_SEVEN  = 4'd7;
    localparam logic [3:0] SUM_ELEVEN = 4'd11;
    localparam logic [3:0] SUM_TWO    = 4'd2;
    localparam logic [3:0] SUM_THREE  = 4'd3;
    localparam logic [3:0] SUM_TWELVE = 4'd12;
    localparam logic [2:0] DIE_MIN    = 3'd1;
    localparam logic [2:0] DIE_MAX    = 3'd6;
endpackage

// File: rtl/dice_counter.sv
// dice_counter: free-running chained 1..6 counter pair; cnt2 steps when cnt1 wraps, 36-cycle period.
module dice_counter
    import craps_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] cnt1,
    output logic [2:0] cnt2
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt1 <= DIE_MIN;
            cnt2 <= DIE_MIN;
        end else begin
            cnt1 <= (cnt1 == DIE_MAX) ? DIE_MIN : cnt1 + 3'd1;
            if (cnt1 == DIE_MAX)
                cnt2 <= (cnt2 == DIE_MAX) ? DIE_MIN : cnt2 + 3'd1;
        end
    end
endmodule

// File: rtl/craps_fsm.sv
// craps_fsm: craps game controller; captures the dice on a roll pulse and applies come-out/point rules.
module craps_fsm
    import craps_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             Clk100MHz,
    input  logic             reset_n,
    input  logic             roll_fe,
    input  logic             new_game,
    output logic [2:0]       die1,
    output logic [2:0]       die2,
    output logic [3:0]       sum,
    output logic [3:0]       point,
    output logic             win,
    output logic             lose,
    output logic [2:0]       game_state,
    output logic [CNT_W-1:0] roll_cnt
);
    craps_state_t state, next_state;
    logic [2:0] cnt1, cnt2;
    logic       capture, win_next, lose_next;

    dice_counter u_dice (
        .clk  (Clk100MHz),
        .rst_n(reset_n),
        .cnt1 (cnt1),
        .cnt2 (cnt2)
    );

    always_ff @(posedge Clk100MHz or negedge reset_n) begin
        if (!reset_n) state <= COMEOUT;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            COMEOUT: next_state = roll_fe ? EVAL_C : COMEOUT;
            EVAL_C:  next_state = (sum == SUM_SEVEN || sum == SUM_ELEVEN) ? WIN :
                                  (sum == SUM_TWO || sum == SUM_THREE || sum == SUM_TWELVE) ? LOSE : POINT;
            POINT:   next_state = roll_fe ? EVAL_P : POINT;
            EVAL_P:  next_state = (sum == point) ? WIN : (sum == SUM_SEVEN) ? LOSE : POINT;
            WIN:     next_state = WIN;
            LOSE:    next_state = LOSE;
            default: next_state = COMEOUT;
        endcase
        if (new_game) next_state = COMEOUT;
    end

    // new_game takes priority, so a coincident roll is neither captured nor counted
    always_comb begin
        capture    = roll_fe && !new_game && (state == COMEOUT || state == POINT);
        win_next   = (next_state == WIN);
        lose_next  = (next_state == LOSE);
        game_state = state;
    end

    always_ff @(posedge Clk100MHz or negedge reset_n) begin
        if (!reset_n) begin
            die1     <= '0;
            die2     <= '0;
            sum      <= '0;
            point    <= '0;
            win      <= 1'b0;
            lose     <= 1'b0;
            roll_cnt <= '0;
        end else begin
            win  <= win_next;
            lose <= lose_next;
            if (capture) begin
                die1 <= cnt1;
                die2 <= cnt2;
                sum  <= {1'b0, cnt1} + {1'b0, cnt2};
            end
            if (new_game)                                point <= '0;
            else if (state == EVAL_C && next_state == POINT) point <= sum;
            if (new_game)                                roll_cnt <= '0;
            else if (capture && roll_cnt != '1)          roll_cnt <= roll_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_craps_fsm.sv
// tb_craps_fsm: scoreboard bench; stimulus queues expected outputs per cycle, a monitor compares them.
module tb_craps_fsm;
    logic       clk = 1'b0;
    logic       reset_n, roll_fe, new_game;
    logic [2:0] die1, die2, game_state;
    logic [3:0] sum, point, roll_cnt;
    logic       win, lose;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int          at;
        string       name;
        logic [22:0] exp;
    } exp_t;
    exp_t q[$];

    craps_fsm #(.CNT_W(4)) dut (
        .Clk100MHz (clk),
        .reset_n   (reset_n),
        .roll_fe   (roll_fe),
        .new_game  (new_game),
        .die1      (die1),
        .die2      (die2),
        .sum       (sum),
        .point     (point),
        .win       (win),
        .lose      (lose),
        .game_state(game_state),
        .roll_cnt  (roll_cnt)
    );

    always #5 clk = ~clk;

    // cycle index k since reset release, used to predict the dice
    always @(posedge clk or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;

    function automatic logic [22:0] pack(int d1, int d2, int s, int p, int w, int l, int gs, int rc);
        return {3'(d1), 3'(d2), 4'(s), 4'(p), 1'(w), 1'(l), 3'(gs), 4'(rc)};
    endfunction

    function automatic int die_a(int k);
        return 1 + k % 6;
    endfunction

    function automatic int die_b(int k);
        return 1 + (k / 6) % 6;
    endfunction

    task automatic chk(string name, logic [22:0] e);
        logic [22:0] act;
        act = {die1, die2, sum, point, win, lose, game_state, roll_cnt};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s at k=%0d: got %h expected %h (die1,die2,sum,point,win,lose,state,cnt)",
                     name, cyc, act, e);
        end
    endtask

    task automatic push(int at, string name, logic [22:0] e);
        exp_t x;
        x.at = at;
        x.name = name;
        x.exp = e;
        q.push_back(x);
    endtask

    task automatic pulse(int k, bit r, bit n, int len = 1);
        while (cyc < k) @(negedge clk);
        if (cyc != k) begin
            errors++;
            checks++;
            $display("FAIL schedule: got k=%0d expected k=%0d", cyc, k);
        end
        roll_fe = r;
        new_game = n;
        repeat (len) @(negedge clk);
        roll_fe = 1'b0;
        new_game = 1'b0;
    endtask

    initial forever begin
        @(negedge clk);
        while (q.size() > 0 && q[0].at <= cyc) begin
            if (q[0].at < cyc) begin
                errors++;
                checks++;
                $display("FAIL %s: missed, got k=%0d expected k=%0d", q[0].name, cyc, q[0].at);
            end else chk(q[0].name, q[0].exp);
            void'(q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n, cnt, d1, d2;
        reset_n = 1'b0;
        roll_fe = 1'b0;
        new_game = 1'b0;
        #3 chk("reset", '0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        // come-out loss (1,1), then a roll in LOSE is ignored
        push(1, "loss_cap", pack(1, 1, 2, 0, 0, 0, 1, 1));
        push(2, "loss", pack(1, 1, 2, 0, 0, 1, 5, 1));
        pulse(0, 1, 0);
        push(5, "lose_hold", pack(1, 1, 2, 0, 0, 1, 5, 1));
        pulse(3, 1, 0);
        push(7, "newgame1", pack(1, 1, 2, 0, 0, 0, 0, 0));
        pulse(6, 0, 1);
        // come-out win (5,2)
        push(11, "win_cap", pack(5, 2, 7, 0, 0, 0, 1, 1));
        push(12, "win", pack(5, 2, 7, 0, 1, 0, 4, 1));
        pulse(10, 1, 0);
        push(14, "newgame2", pack(5, 2, 7, 0, 0, 0, 0, 0));
        pulse(13, 0, 1);
        // point 5 then seven-out with (4,3) at k=51
        push(19, "pt_cap", pack(1, 4, 5, 0, 0, 0, 1, 1));
        push(20, "pt_set", pack(1, 4, 5, 5, 0, 0, 2, 1));
        pulse(18, 1, 0);
        push(52, "seven_cap", pack(4, 3, 7, 5, 0, 0, 3, 2));
        push(53, "seven_out", pack(4, 3, 7, 5, 0, 1, 5, 2));
        pulse(51, 1, 0);
        push(56, "newgame3", pack(4, 3, 7, 0, 0, 0, 0, 0));
        pulse(55, 0, 1);
        // point 5, a non-resolving 3, then point made with (3,2)
        push(76, "pt2_cap", pack(4, 1, 5, 0, 0, 0, 1, 1));
        push(77, "pt2_set", pack(4, 1, 5, 5, 0, 0, 2, 1));
        pulse(75, 1, 0);
        push(79, "miss_cap", pack(1, 2, 3, 5, 0, 0, 3, 2));
        push(80, "miss", pack(1, 2, 3, 5, 0, 0, 2, 2));
        pulse(78, 1, 0);
        push(117, "make_cap", pack(3, 2, 5, 5, 0, 0, 3, 3));
        push(118, "make", pack(3, 2, 5, 5, 1, 0, 4, 3));
        pulse(116, 1, 0);
        // simultaneous new_game and roll while in POINT
        push(121, "newgame4", pack(3, 2, 5, 0, 0, 0, 0, 0));
        pulse(120, 0, 1);
        push(123, "pt6_cap", pack(3, 3, 6, 0, 0, 0, 1, 1));
        push(124, "pt6_set", pack(3, 3, 6, 6, 0, 0, 2, 1));
        pulse(122, 1, 0);
        push(127, "simul", pack(3, 3, 6, 0, 0, 0, 0, 0));
        push(128, "simul_hold", pack(3, 3, 6, 0, 0, 0, 0, 0));
        pulse(126, 1, 1);
        // two-cycle roll: second cycle lands in EVAL_C and is dropped
        push(130, "pt8_cap", pack(4, 4, 8, 0, 0, 0, 1, 1));
        push(131, "pt8_set", pack(4, 4, 8, 8, 0, 0, 2, 1));
        pulse(129, 1, 0, 2);
        // 20 non-resolving point rolls saturate roll_cnt at 15
        k = 132;
        n = 1;
        cnt = 0;
        while (cnt < 20) begin
            d1 = die_a(k);
            d2 = die_b(k);
            if (d1 + d2 != 7 && d1 + d2 != 8) begin
                n = (n < 15) ? n + 1 : 15;
                push(k + 1, "sat_cap", pack(d1, d2, d1 + d2, 8, 0, 0, 3, n));
                push(k + 2, "sat", pack(d1, d2, d1 + d2, 8, 0, 0, 2, n));
                pulse(k, 1, 0);
                cnt++;
                k += 3;
            end else k++;
        end
        // a winning roll interrupted by reset while in EVAL_P
        while (die_a(k) + die_b(k) != 8) k++;
        while (cyc < k) @(negedge clk);
        roll_fe = 1'b1;
        @(posedge clk);
        #1 roll_fe = 1'b0;
        chk("evalp_pre", pack(die_a(k), die_b(k), 8, 8, 0, 0, 3, 15));
        #2 reset_n = 1'b0;
        #1 chk("rst_async", '0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold", '0);
        reset_n = 1'b1;
        // fresh game after reset: (6,1) at k=5 wins
        push(6, "post_cap", pack(6, 1, 7, 0, 0, 0, 1, 1));
        push(7, "post_win", pack(6, 1, 7, 0, 1, 0, 4, 1));
        pulse(5, 1, 0);
        repeat (3) @(negedge clk);
        while (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL %s: got no check expected one at k=%0d", q[0].name, q[0].at);
            void'(q.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
